// File: rtl/br_pkg.sv
// Shared encodings, counter constants and pc field extraction for the branch predictor.
package br_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BGTZ = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BLTZ = 3'd4,
    BR_BGEZ = 3'd5,
    BR_J    = 3'd6,
    BR_RSVD = 3'd7
  } br_op_e;

  localparam logic [1:0] CNT_INIT = 2'b01;
  localparam logic [1:0] CNT_MAX  = 2'b11;
  localparam logic [1:0] CNT_MIN  = 2'b00;

  // Extract a w-bit field starting at bit lsb of a pc (index or tag).
  function automatic logic [63:0] pc_field(input logic [63:0] pc,
                                           input int unsigned lsb,
                                           input int unsigned w);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (pc >> lsb) & mask;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition and target evaluation for all MIPS branch/jump kinds.
module branch_cond_eval #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [2:0]        ex_op,
  input  logic [31:0]       rdata_a,
  input  logic [31:0]       rdata_b,
  input  logic [ADDR_W-1:0] ex_next_pc,
  input  logic [25:0]       ex_imme,
  output logic              taken_c,
  output logic [ADDR_W-1:0] target_c
);
  import br_pkg::*;

  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] cond_target;
  logic [ADDR_W-1:0] jmp_target;

  // Word offset, sign-extended; sum wraps naturally at ADDR_W bits.
  assign br_off      = {{(ADDR_W-16){ex_imme[15]}}, ex_imme[15:0]} << 2;
  assign cond_target = ex_next_pc + br_off;
  assign jmp_target  = {ex_next_pc[ADDR_W-1:28], ex_imme, 2'b00};

  // Condition decode per branch kind; reserved op never takes.
  always_comb begin
    taken_c  = 1'b0;
    target_c = cond_target;
    case (br_op_e'(ex_op))
      BR_BEQ:  taken_c = (rdata_a == rdata_b);
      BR_BNE:  taken_c = (rdata_a != rdata_b);
      BR_BGTZ: taken_c = ($signed(rdata_a) > 32'sd0);
      BR_BLEZ: taken_c = ($signed(rdata_a) <= 32'sd0);
      BR_BLTZ: taken_c = rdata_a[31];
      BR_BGEZ: taken_c = ~rdata_a[31];
      BR_J: begin
        taken_c  = 1'b1;
        target_c = jmp_target;
      end
      default: taken_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predictor: BHT + tagged BTB lookup in IF, resolve and redirect from EX, statistics.
module branch_predict_unit #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned TAG_W       = 8,
  parameter logic [1:0]  CNT_INIT    = br_pkg::CNT_INIT,
  parameter int unsigned STAT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              ex_valid,
  input  logic [2:0]        ex_op,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [ADDR_W-1:0] ex_next_pc,
  input  logic [25:0]       ex_imme,
  input  logic [31:0]       rdata_a,
  input  logic [31:0]       rdata_b,
  input  logic              ex_pred_taken,
  input  logic [ADDR_W-1:0] ex_pred_target,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispred_cnt
);
  import br_pkg::*;

  localparam int unsigned INDEX_W = $clog2(BHT_ENTRIES);

  logic [1:0]        cnt_q        [BHT_ENTRIES];
  logic [1:0]        cnt_d        [BHT_ENTRIES];
  logic [TAG_W-1:0]  btb_tag_q    [BHT_ENTRIES];
  logic [TAG_W-1:0]  btb_tag_d    [BHT_ENTRIES];
  logic [ADDR_W-1:0] btb_target_q [BHT_ENTRIES];
  logic [ADDR_W-1:0] btb_target_d [BHT_ENTRIES];
  logic [BHT_ENTRIES-1:0] btb_valid_q, btb_valid_d;

  logic              redirect_valid_q, redirect_valid_d;
  logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
  logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [STAT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [INDEX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0]   if_tag, ex_tag;
  logic               act_taken;
  logic [ADDR_W-1:0]  act_target;
  logic               eff_valid;
  logic               mispredict;

  // Table index/tag for the fetch pc and the resolving pc.
  assign if_idx = INDEX_W'(pc_field(64'(if_pc), 2, INDEX_W));
  assign if_tag = TAG_W'(pc_field(64'(if_pc), INDEX_W + 2, TAG_W));
  assign ex_idx = INDEX_W'(pc_field(64'(ex_pc), 2, INDEX_W));
  assign ex_tag = TAG_W'(pc_field(64'(ex_pc), INDEX_W + 2, TAG_W));

  // IF lookup reads registered tables only, so same-cycle updates are not seen.
  assign pred_taken  = btb_valid_q[if_idx] & (btb_tag_q[if_idx] == if_tag) & cnt_q[if_idx][1];
  assign pred_target = btb_target_q[if_idx];

  branch_cond_eval #(
    .ADDR_W (ADDR_W)
  ) u_cond (
    .ex_op      (ex_op),
    .rdata_a    (rdata_a),
    .rdata_b    (rdata_b),
    .ex_next_pc (ex_next_pc),
    .ex_imme    (ex_imme),
    .taken_c    (act_taken),
    .target_c   (act_target)
  );

  // An EX slot right behind a redirect is wrong-path; reserved op is ignored.
  assign eff_valid  = ex_valid & ~redirect_valid_q & (ex_op != BR_RSVD);
  assign mispredict = (act_taken != ex_pred_taken) |
                      (act_taken & (act_target != ex_pred_target));

  // Next-state of BHT counters and BTB entries.
  always_comb begin
    cnt_d        = cnt_q;
    btb_valid_d  = btb_valid_q;
    btb_tag_d    = btb_tag_q;
    btb_target_d = btb_target_q;
    if (eff_valid) begin
      if (ex_op == BR_J) begin
        cnt_d[ex_idx] = CNT_MAX;
      end else if (act_taken) begin
        if (cnt_q[ex_idx] != CNT_MAX) cnt_d[ex_idx] = cnt_q[ex_idx] + 2'd1;
      end else begin
        if (cnt_q[ex_idx] != CNT_MIN) cnt_d[ex_idx] = cnt_q[ex_idx] - 2'd1;
      end
      if (act_taken) begin
        btb_valid_d[ex_idx]  = 1'b1;
        btb_tag_d[ex_idx]    = ex_tag;
        btb_target_d[ex_idx] = act_target;
      end
    end
  end

  // Next-state of redirect pulse and saturating statistics.
  always_comb begin
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    branch_cnt_d     = branch_cnt_q;
    mispred_cnt_d    = mispred_cnt_q;
    if (eff_valid) begin
      redirect_valid_d = mispredict;
      redirect_pc_d    = act_taken ? act_target : ex_next_pc;
      if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + STAT_W'(1);
      if (mispredict && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + STAT_W'(1);
    end
  end

  // Table storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        cnt_q[i]        <= CNT_INIT;
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= '0;
      end
      btb_valid_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      btb_valid_q  <= btb_valid_d;
      btb_tag_q    <= btb_tag_d;
      btb_target_q <= btb_target_d;
    end
  end

  // Redirect and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      branch_cnt_q     <= '0;
      mispred_cnt_q    <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      branch_cnt_q     <= branch_cnt_d;
      mispred_cnt_q    <= mispred_cnt_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the single-cycle branch comparator.
- Adds a direct-mapped branch history table (2-bit saturating counters) plus a tagged target buffer, looked up in IF.
- Resolves all MIPS branch/jump kinds in EX and drives a registered redirect/flush to pc and the pipeline on misprediction.
- Keeps mispredict/branch statistics counters.

Parameters:
- ADDR_W, 32, PC and target width.
- BHT_ENTRIES, 64, table depth (power of 2); INDEX_W = log2(BHT_ENTRIES).
- TAG_W, 8, BTB tag bits taken from pc[INDEX_W+2 +: TAG_W].
- CNT_INIT, 2'b01, counter reset value (weakly not-taken).
- STAT_W, 32, width of statistics counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- if_pc  in  ADDR_W  fetch pc.
- pred_taken  out  1  IF prediction (combinational from tables).
- pred_target  out  ADDR_W  predicted target; valid only when pred_taken=1.
- ex_valid  in  1  EX holds a branch/jump instruction.
- ex_op  in  3  0 BEQ, 1 BNE, 2 BGTZ, 3 BLEZ, 4 BLTZ, 5 BGEZ, 6 J/JAL, 7 reserved.
- ex_pc  in  ADDR_W  branch pc.
- ex_next_pc  in  ADDR_W  ex_pc+4.
- ex_imme  in  26  raw immediate field.
- rdata_a  in  32  rs value.
- rdata_b  in  32  rt value.
- ex_pred_taken  in  1  prediction carried down from IF.
- ex_pred_target  in  ADDR_W  predicted target carried from IF.
- redirect_valid  out  1  registered flush/redirect pulse.
- redirect_pc  out  ADDR_W  correct next pc.
- branch_cnt  out  STAT_W  resolved branches.
- mispred_cnt  out  STAT_W  mispredictions.

Behaviour:
- Reset (async, rst_n=0):
  - all counters = CNT_INIT; all BTB valid bits = 0.
  - redirect_valid = 0; redirect_pc = 0; branch_cnt = mispred_cnt = 0.
- Lookup (combinational read of registered arrays):
  - idx = if_pc[INDEX_W+1:2].
  - pred_taken = btb_valid[idx] & (tag match) & counter[idx][1].
  - pred_target = btb_target[idx].
  - Same-cycle update to the same idx is not visible: read-before-write.
- Resolve (combinational, EX):
  - BEQ: a==b. BNE: a!=b.
  - BGTZ: a signed >0. BLEZ: a signed <=0. BLTZ: a[31]. BGEZ: !a[31].
  - J: always taken.
  - Conditional target = ex_next_pc + (sign-extend ex_imme[15:0] << 2), wrap modulo 2^ADDR_W.
  - J target = {ex_next_pc[31:28], ex_imme, 2'b00}.
  - ex_op 7 is treated as not taken, no table update, not counted.
- Mispredict = actual_taken != ex_pred_taken, or (actual_taken & target != ex_pred_target).
- Redirect timing (one-cycle latency):
  - On a clock edge with an effective ex_valid: redirect_valid <= mispredict.
  - redirect_pc <= actual_taken ? target : ex_next_pc.
  - Otherwise redirect_valid <= 0; redirect_pc holds.
- Wrong-path masking: ex_valid is ignored while redirect_valid=1 (that EX slot is wrong-path). No update, no count, no new redirect.
- Table update, on an effective ex_valid with ex_op in 0..6:
  - Counter saturates: increment if taken (max 3), decrement if not taken (min 0). J writes 3.
  - If taken: BTB entry written with valid=1, tag, target.
  - If not taken: BTB entry is left unchanged.
- Statistics: branch_cnt +1 per effective resolve; mispred_cnt +1 per mispredict. Both saturate at all-ones; no wrap.
- Reset mid-operation: everything returns to reset values asynchronously. A pending redirect is dropped.

Decomposition:
- Package br_pkg holds:
  - ex_op encodings BR_BEQ..BR_J.
  - CNT_INIT, CNT_MAX = 2'b11, CNT_MIN = 2'b00.
  - Helper function for index/tag extraction.
- One sub-module, branch_cond_eval: purely combinational condition and target computation (ex_op, operands, pc, imme -> taken, target). The main module keeps the tables, redirect register and counters.

Test Plan:
- Reset, then if_pc=0x00400000 -> pred_taken=0; after reset release, redirect_valid=0 and both counts 0.
- BEQ at 0x00400010, a=b=5, imm=0x0004, ex_pred_taken=0 -> next cycle redirect_valid=1, redirect_pc=0x00400024, mispred_cnt=1. Later lookup of 0x00400010 -> pred_taken=0 (counter 2'b10? no: 01->10, so pred_taken=1, pred_target=0x00400024).
- Same BEQ resolved taken 3 more times, then not taken with prediction taken -> counter 3->2, redirect_pc=0x00400014, mispred_cnt increments, predict still taken.
- BNE with imm=0xFFFF at 0x00400100, a=1, b=2 -> target 0x00400100; BLEZ with a=0x80000000 taken; BGTZ with a=0 not taken.
- J at 0x0FFFFFFC, imme=0x0000010 -> target 0x10000040; the cycle after the redirect pulse, assert ex_valid with a mispredicting BNE -> no redirect, counts unchanged.
- Assert rst_n=0 mid-redirect -> redirect_valid drops to 0 immediately; previously trained entry predicts not taken after reset.
